cpu_trace_buffer: RTL and testbench

- Synthesizable trace unit that watches the multicycle CPU's PC, opcode, control-FSM state and N_CH datapath channels (ULA out, Reg A/B, Mux A/B).
- Captures a timestamped entry whenever PC or FSM state changes, and stores entries in a FIFO for drain through a valid/ready port.
- Stops by itself after a programmable cycle budget, replacing bench-side printing and time-limit stopping with hardware capture usable in both simulation and silicon.

---
 rtl/cpu_trace_buffer_pkg.sv | 30 +++
 rtl/cpu_trace_buffer_fifo.sv | 79 +++++++
 rtl/cpu_trace_buffer.sv | 136 +++++++++++++
 tb/tb_cpu_trace_buffer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the CPU trace buffer: FSM state encoding, entry layout and entry width helper.
package cpu_trace_pkg;

    localparam int TRACE_DATA_W  = 64;
    localparam int TRACE_N_CH    = 5;
    localparam int TRACE_STATE_W = 3;
    localparam int TRACE_CYC_W   = 16;
    localparam int TRACE_OPC_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } trace_state_t;

    // Field order (MSB first) is the packing order used for the flat FIFO word.
    typedef struct packed {
        logic [TRACE_DATA_W-1:0]            pc;
        logic [TRACE_OPC_W-1:0]             opcode;
        logic [TRACE_STATE_W-1:0]           stt;
        logic [TRACE_N_CH*TRACE_DATA_W-1:0] ch;
        logic [TRACE_CYC_W-1:0]             cycle;
    } trace_entry_t;

    function automatic int entry_width(input int data_w, input int n_ch,
                                       input int state_w, input int cyc_w);
        return data_w + TRACE_OPC_W + state_w + n_ch * data_w + cyc_w;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Generic synchronous FIFO with level count, flush, and optional overwrite-oldest on full.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wrap_en,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;

    logic full;
    logic empty;
    logic do_pop;
    logic blocked;
    logic do_write;
    logic overwrite;
    logic advance_rd;

    assign full       = (level_reg == LVL_W'(DEPTH));
    assign empty      = (level_reg == '0);
    assign do_pop     = pop && !empty && !clear;
    // A push into a full FIFO with no pop to make room.
    assign blocked    = push && full && !do_pop && !clear;
    assign do_write   = push && !clear && (!blocked || wrap_en);
    assign overwrite  = blocked && wrap_en;
    assign advance_rd = do_pop || overwrite;
    assign dropped    = blocked;

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (advance_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // An overwrite replaces the oldest entry, so it never changes the count.
            if (do_write && !overwrite && !do_pop) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (do_pop && !do_write) begin
                level_reg <= level_reg - LVL_W'(1);
            end
        end
    end

    // Head slot is read directly; an empty FIFO presents zeros rather than stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];
    assign level    = level_reg;

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU trace unit: timestamps PC/FSM-state changes into a FIFO and self-halts after MAX_CYCLES.
// Define TRACE_WRAP_EN to keep the newest DEPTH entries on overflow instead of dropping new ones.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W     = TRACE_DATA_W,
    parameter int N_CH       = TRACE_N_CH,
    parameter int STATE_W    = TRACE_STATE_W,
    parameter int DEPTH      = 16,
    parameter int CYC_W      = TRACE_CYC_W,
    parameter int MAX_CYCLES = 30
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        pc,
    input  logic [31:0]              opcode,
    input  logic [STATE_W-1:0]       stt,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_pc,
    output logic [31:0]              rd_opcode,
    output logic [STATE_W-1:0]       rd_stt,
    output logic [N_CH*DATA_W-1:0]   rd_ch,
    output logic [CYC_W-1:0]         rd_cycle,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     halted
);

    localparam int ENTRY_W = entry_width(DATA_W, N_CH, STATE_W, CYC_W);
    localparam logic [CYC_W-1:0] LAST_CYCLE = CYC_W'(MAX_CYCLES - 1);
`ifdef TRACE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    trace_state_t       state_reg;
    logic [CYC_W-1:0]   cycle_reg;
    logic               prev_valid_reg;
    logic [DATA_W-1:0]  prev_pc_reg;
    logic [STATE_W-1:0] prev_stt_reg;
    logic               overflow_reg;
    logic               busy_reg;
    logic               halted_reg;

    logic               capture;
    logic               fifo_dropped;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign capture = (state_reg == ARMED) &&
                     (!prev_valid_reg || (pc != prev_pc_reg) || (stt != prev_stt_reg));

    assign push_entry = {pc, opcode, stt, ch_data, cycle_reg};

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .wrap_en   (WRAP_EN),
        .push      (capture),
        .push_data (push_entry),
        .pop       (rd_ready),
        .pop_data  (head_entry),
        .level     (level),
        .dropped   (fifo_dropped)
    );

    assign {rd_pc, rd_opcode, rd_stt, rd_ch, rd_cycle} = head_entry;
    assign rd_valid = (level != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cycle_reg      <= '0;
            prev_valid_reg <= 1'b0;
            prev_pc_reg    <= '0;
            prev_stt_reg   <= '0;
            overflow_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            halted_reg     <= 1'b0;
        end else if (clear) begin
            state_reg      <= IDLE;
            prev_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            halted_reg     <= 1'b0;
        end else begin
            if (fifo_dropped) begin
                overflow_reg <= 1'b1;
            end
            unique case (state_reg)
                IDLE, HALTED: begin
                    if (arm) begin
                        state_reg  <= ARMED;
                        cycle_reg  <= '0;
                        busy_reg   <= 1'b1;
                        halted_reg <= 1'b0;
                    end
                end
                ARMED: begin
                    prev_pc_reg  <= pc;
                    prev_stt_reg <= stt;
                    cycle_reg    <= cycle_reg + CYC_W'(1);
                    // The capture on the final cycle still lands; only the window closes.
                    if (cycle_reg == LAST_CYCLE) begin
                        state_reg      <= HALTED;
                        prev_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        halted_reg     <= 1'b1;
                    end else begin
                        prev_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign overflow = overflow_reg;
    assign busy     = busy_reg;
    assign halted   = halted_reg;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed scoreboard bench for cpu_trace_buffer; honours TRACE_WRAP_EN when defined.
module tb_cpu_trace_buffer;

    localparam int DATA_W  = 64;
    localparam int N_CH    = 5;
    localparam int STATE_W = 3;
    localparam int DEPTH   = 16;
    localparam int CYC_W   = 16;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic                   clock    = 1'b0;
    logic                   reset    = 1'b1;
    logic                   arm      = 1'b0;
    logic                   clear    = 1'b0;
    logic [DATA_W-1:0]      pc       = '0;
    logic [STATE_W-1:0]     stt      = '0;
    logic                   rd_ready = 1'b0;
    logic [31:0]            opcode;
    logic [N_CH*DATA_W-1:0] ch_data;

    logic                   rd_valid;
    logic [DATA_W-1:0]      rd_pc;
    logic [31:0]            rd_opcode;
    logic [STATE_W-1:0]     rd_stt;
    logic [N_CH*DATA_W-1:0] rd_ch;
    logic [CYC_W-1:0]       rd_cycle;
    logic [LVL_W-1:0]       level;
    logic                   overflow;
    logic                   busy;
    logic                   halted;

    typedef struct {
        logic [DATA_W-1:0]  pc;
        logic [STATE_W-1:0] stt;
        logic [CYC_W-1:0]   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] op_of(input logic [DATA_W-1:0] p);
        return 32'hC0DE_0000 ^ p[31:0];
    endfunction

    function automatic logic [N_CH*DATA_W-1:0] ch_of(input logic [DATA_W-1:0] p);
        logic [N_CH*DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            r[k*DATA_W +: DATA_W] = p + (64'(k + 1) << 40);
        end
        return r;
    endfunction

    assign opcode  = op_of(pc);
    assign ch_data = ch_of(pc);

    cpu_trace_buffer #(
        .DATA_W     (DATA_W),
        .N_CH       (N_CH),
        .STATE_W    (STATE_W),
        .DEPTH      (DEPTH),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (30)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .clear     (clear),
        .pc        (pc),
        .opcode    (opcode),
        .stt       (stt),
        .ch_data   (ch_data),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_pc     (rd_pc),
        .rd_opcode (rd_opcode),
        .rd_stt    (rd_stt),
        .rd_ch     (rd_ch),
        .rd_cycle  (rd_cycle),
        .level     (level),
        .overflow  (overflow),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("check %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] p, input logic [STATE_W-1:0] s,
                            input logic [CYC_W-1:0] c);
        exp_t e;
        e.pc  = p;
        e.stt = s;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid; i++) tick();
        rd_ready = 0;
        check(name, 64'(level), 64'd0);
    endtask

    // Monitor: every accepted head entry is compared against the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && rd_valid && rd_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop: got pc=0x%0h cyc=%0d, required no entry", rd_pc, rd_cycle);
            end else begin
                e = exp_q.pop_front();
                if (rd_pc !== e.pc || rd_stt !== e.stt || rd_cycle !== e.cyc ||
                    rd_opcode !== op_of(e.pc) || rd_ch !== ch_of(e.pc)) begin
                    n_err++;
                    $display("FAIL pop: got pc=0x%0h stt=%0d cyc=%0d op=0x%0h, required pc=0x%0h stt=%0d cyc=%0d op=0x%0h",
                             rd_pc, rd_stt, rd_cycle, rd_opcode, e.pc, e.stt, e.cyc, op_of(e.pc));
                end else begin
                    $display("pop pc=0x%0h stt=%0d cyc=%0d", rd_pc, rd_stt, rd_cycle);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_rd_valid", 64'(rd_valid), 64'd0);
            check("rst_level",    64'(level),    64'd0);
            check("rst_halted",   64'(halted),   64'd0);
            check("rst_overflow", 64'(overflow), 64'd0);
        end
        tick();
        reset = 1'b0;
        tick();

        // Constant PC, state walks 0 -> 1 -> 2
        pc  = 64'h0;
        stt = 3'd0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy", 64'(busy), 64'd1);
        push_exp(64'h0, 3'd0, 16'd0);
        tick();
        stt = 3'd1;
        push_exp(64'h0, 3'd1, 16'd1);
        tick();
        stt = 3'd2;
        push_exp(64'h0, 3'd2, 16'd2);
        tick();
        check("stt_level", 64'(level), 64'd3);
        for (int i = 0; i < 60 && !halted; i++) tick();
        check("stt_halted", 64'(halted), 64'd1);
        check("stt_busy",   64'(busy),   64'd0);
        check("stt_level_after_halt", 64'(level), 64'd3);
        drain("stt_drain");

        // PC changes every cycle for the full window, no reads
        pc  = 64'h1000;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 30; i++) begin
            pc  = 64'h1000 + 64'(4 * i);
            stt = 3'(i);
`ifdef TRACE_WRAP_EN
            if (i >= 14) push_exp(pc, stt, 16'(i));
`else
            if (i < 16) push_exp(pc, stt, 16'(i));
`endif
            tick();
        end
        check("ovf_halted",   64'(halted),   64'd1);
        check("ovf_level",    64'(level),    64'd16);
        check("ovf_overflow", 64'(overflow), 64'd1);
        drain("ovf_drain");
        check("ovf_sticky", 64'(overflow), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_overflow", 64'(overflow), 64'd0);
        check("clr_halted",   64'(halted),   64'd0);

        // Fill to full, then capture and pop on the same edge
        pc  = 64'h2000;
        stt = 3'd3;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc = 64'h2000 + 64'(8 * i);
            push_exp(pc, 3'd3, 16'(i));
            tick();
        end
        check("full_level",    64'(level),    64'd16);
        check("full_overflow", 64'(overflow), 64'd0);
        pc = 64'h2000 + 64'(8 * 16);
        push_exp(pc, 3'd3, 16'd16);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("fullpp_level",    64'(level),    64'd16);
        check("fullpp_overflow", 64'(overflow), 64'd0);
        check("fullpp_head_cyc", 64'(rd_cycle), 64'd1);

        // Drain down to five entries while still armed, then clear with rd_ready high
        rd_ready = 1'b1;
        repeat (11) tick();
        rd_ready = 1'b0;
        check("pre_clr_level", 64'(level), 64'd5);
        check("pre_clr_busy",  64'(busy),  64'd1);
        clear    = 1'b1;
        rd_ready = 1'b1;
        tick();
        clear    = 1'b0;
        rd_ready = 1'b0;
        exp_q.delete();
        check("clr_level",    64'(level),    64'd0);
        check("clr_busy",     64'(busy),     64'd0);
        check("clr_overflow2", 64'(overflow), 64'd0);
        check("clr_rd_valid", 64'(rd_valid), 64'd0);

        // Asynchronous reset between edges while armed
        pc  = 64'h3000;
        stt = 3'd5;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc = 64'h3000 + 64'(16 * i);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_rd_valid", 64'(rd_valid), 64'd0);
        check("arst_level",    64'(level),    64'd0);
        check("arst_busy",     64'(busy),     64'd0);
        check("arst_rd_pc",    rd_pc,         64'd0);
        tick();
        reset = 1'b0;
        pc  = 64'h4000;
        stt = 3'd6;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        push_exp(64'h4000, 3'd6, 16'd0);
        repeat (4) tick();
        check("rearm_level", 64'(level),    64'd1);
        check("rearm_cycle", 64'(rd_cycle), 64'd0);
        drain("rearm_drain");
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
